// File: rtl/rv32i_inst_encoder_if.sv
// Request/write bus between an instruction source and the RV32I encoder.
// The encoder side uses the slave modport; the driving side uses master.
interface rv32i_inst_encoder_if #(
  parameter int unsigned DEPTH_WORDS = 256
);
  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       fmt;
  logic [4:0]       alu_op;
  logic [2:0]       funct3_in;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             done;
  logic             imem_we;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_wdata;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             err;

  modport slave (
    input  in_valid, fmt, alu_op, funct3_in, rd, rs1, rs2, imm, done,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );

  modport master (
    output in_valid, fmt, alu_op, funct3_in, rd, rs1, rs2, imm, done,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Packs decoded RV32I fields into machine words and writes them to
// consecutive instruction-memory locations, one word per two cycles.
module rv32i_inst_encoder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  rv32i_inst_encoder_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             legal_c;
  logic [31:0]      word_c;

  function automatic logic [2:0] alu_funct3(input logic [4:0] op);
    case (op)
      5'd2:       alu_funct3 = 3'b001;
      5'd3:       alu_funct3 = 3'b010;
      5'd4:       alu_funct3 = 3'b011;
      5'd5:       alu_funct3 = 3'b100;
      5'd6, 5'd7: alu_funct3 = 3'b101;
      5'd8:       alu_funct3 = 3'b110;
      5'd9:       alu_funct3 = 3'b111;
      default:    alu_funct3 = 3'b000;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] f, input logic [4:0] op,
                                    input logic [2:0] f3);
    logic ok;
    ok = (f <= 4'd8) && (op <= 5'd10);
    if ((f == 4'd0 || f == 4'd1) && op == 5'd10) ok = 1'b0;
    if (f == 4'd1 && op == 5'd1) ok = 1'b0;
    if (f == 4'd6 && (f3 == 3'b010 || f3 == 3'b011)) ok = 1'b0;
    if (f == 4'd2 && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ok = 1'b0;
    if (f == 4'd3 && (f3[2] || f3 == 3'b011)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] f, input logic [4:0] op,
                                         input logic [2:0] f3, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2,
                                         input logic [31:0] im);
    logic [2:0] af3;
    logic [6:0] f7;
    logic       shift;
    af3   = alu_funct3(op);
    f7    = (op == 5'd1 || op == 5'd7) ? 7'b0100000 : 7'b0000000;
    shift = (op == 5'd2 || op == 5'd6 || op == 5'd7);
    case (f)
      4'd0:    encode = {f7, s2, s1, af3, d, 7'b0110011};
      4'd1:    encode = shift ? {f7, im[4:0], s1, af3, d, 7'b0010011}
                              : {im[11:0], s1, af3, d, 7'b0010011};
      4'd2:    encode = {im[11:0], s1, f3, d, 7'b0000011};
      4'd3:    encode = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
      4'd4:    encode = {im[31:12], d, 7'b0110111};
      4'd5:    encode = {im[31:12], d, 7'b0010111};
      4'd6:    encode = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
      4'd7:    encode = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
      4'd8:    encode = {im[11:0], s1, 3'b000, d, 7'b1100111};
      default: encode = 32'h0000_0000;
    endcase
  endfunction

  assign legal_c = is_legal(bus.fmt, bus.alu_op, bus.funct3_in);
  assign word_c  = encode(bus.fmt, bus.alu_op, bus.funct3_in, bus.rd,
                          bus.rs1, bus.rs2, bus.imm);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && ready_q) begin
          if (bus.done) begin
            state_d = S_FINISH;
          end else if (!legal_c) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + (32'(count_q) << 2);
            wdata_d = word_c;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + CNT_W'(1);
        full_d  = (count_d == CNT_W'(DEPTH_WORDS));
        state_d = S_IDLE;
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) && !full_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Bench for rv32i_inst_encoder: directed vectors, randomized requests against
// an arithmetic encoding model, and capacity / reset / end-of-program sequences.
module tb_rv32i_inst_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_inst_encoder_if #(.DEPTH_WORDS(256)) bus ();
  rv32i_inst_encoder_if #(.DEPTH_WORDS(4))   sb ();

  rv32i_inst_encoder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  rv32i_inst_encoder #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0000)) dut_small (
    .clk(clk), .rst(rst), .bus(sb));

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  aop;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder: builds the word by weighted field sums from the format rules.
  function automatic void ref_enc(input vec_t v, output logic legal, output logic [31:0] w);
    logic [31:0] opc_tab [9];
    logic [31:0] af3_tab [10];
    logic [31:0] im, op, f3a, f7, f3;
    opc_tab = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h37, 32'h17, 32'h63, 32'h6F, 32'h67};
    af3_tab = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    im  = v.imm;
    f3  = 32'(v.f3);
    legal = 1'b1;
    if (v.fmt > 8 || v.aop > 10) legal = 1'b0;
    if (v.fmt <= 1 && v.aop == 10) legal = 1'b0;
    if (v.fmt == 1 && v.aop == 1) legal = 1'b0;
    if (v.fmt == 6 && (v.f3 == 2 || v.f3 == 3)) legal = 1'b0;
    if (v.fmt == 2 && !(v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 1'b0;
    if (v.fmt == 3 && v.f3 > 2) legal = 1'b0;
    w = 0;
    if (!legal) return;
    op  = opc_tab[v.fmt];
    f3a = (v.aop <= 9) ? af3_tab[v.aop] : 0;
    f7  = (v.aop == 1 || v.aop == 7) ? 32 : 0;
    case (v.fmt)
      0: w = op + v.rd * 128 + f3a * 4096 + v.rs1 * 32768 + v.rs2 * 1048576 + f7 * 33554432;
      1: if (v.aop == 2 || v.aop == 6 || v.aop == 7)
           w = op + v.rd * 128 + f3a * 4096 + v.rs1 * 32768 + (im % 32) * 1048576 + f7 * 33554432;
         else
           w = op + v.rd * 128 + f3a * 4096 + v.rs1 * 32768 + (im % 4096) * 1048576;
      2: w = op + v.rd * 128 + f3 * 4096 + v.rs1 * 32768 + (im % 4096) * 1048576;
      8: w = op + v.rd * 128 + v.rs1 * 32768 + (im % 4096) * 1048576;
      3: w = op + (im % 32) * 128 + f3 * 4096 + v.rs1 * 32768 + v.rs2 * 1048576
             + ((im / 32) % 128) * 33554432;
      4, 5: w = op + v.rd * 128 + (im / 4096) * 4096;
      6: w = op + ((im / 2048) % 2) * 128 + ((im / 2) % 16) * 256 + f3 * 4096 + v.rs1 * 32768
             + v.rs2 * 1048576 + ((im / 32) % 64) * 33554432 + ((im / 4096) % 2) * 32'h8000_0000;
      7: w = op + v.rd * 128 + ((im / 4096) % 256) * 4096 + ((im / 2048) % 2) * 1048576
             + ((im / 2) % 1024) * 2097152 + ((im / 1048576) % 2) * 32'h8000_0000;
      default: w = 0;
    endcase
  endfunction

  task automatic drive(input vec_t v, input logic dn);
    bus.fmt = v.fmt; bus.alu_op = v.aop; bus.funct3_in = v.f3;
    bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.imm = v.imm;
    bus.done = dn; bus.in_valid = 1'b1;
  endtask

  task automatic do_req(input vec_t v, input string name);
    int waitc = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!bus.in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL %s: in_ready stuck low got 0 expected 1", name);
      return;
    end
    drive(v, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (v.legal) begin
      chk({name, " we"}, 32'(bus.imem_we), 32'd1);
      chk({name, " addr"}, bus.imem_addr, 32'(exp_count * 4));
      chk({name, " wdata"}, bus.imem_wdata, v.word);
      chk({name, " ready_in_write"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      exp_count++;
      chk({name, " we_drop"}, 32'(bus.imem_we), 32'd0);
    end else begin
      exp_err = 1'b1;
      chk({name, " we"}, 32'(bus.imem_we), 32'd0);
      chk({name, " ready"}, 32'(bus.in_ready), 32'd1);
    end
    chk({name, " count"}, 32'(bus.count), 32'(exp_count));
    chk({name, " err"}, 32'(bus.err), 32'(exp_err));
  endtask

  vec_t tbl [9];
  logic [31:0] waddrs [$];

  initial begin
    vec_t v;
    logic lg;
    logic [31:0] w;
    bus.in_valid = 0; bus.fmt = 0; bus.alu_op = 0; bus.funct3_in = 0; bus.rd = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.done = 0;
    sb.in_valid = 0; sb.fmt = 0; sb.alu_op = 0; sb.funct3_in = 0; sb.rd = 0;
    sb.rs1 = 0; sb.rs2 = 0; sb.imm = 0; sb.done = 0;

    //          fmt aop f3 rd rs1 rs2 imm            legal word
    tbl[0] = '{0, 0, 0, 3, 1, 2, 32'h0,        1, 32'h002081B3};
    tbl[1] = '{0, 1, 0, 5, 6, 7, 32'h0,        1, 32'h407302B3};
    tbl[2] = '{1, 7, 0, 1, 2, 0, 32'h3,        1, 32'h40315093};
    tbl[3] = '{3, 0, 2, 0, 1, 2, 32'h8,        1, 32'h0020A423};
    tbl[4] = '{6, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 1, 32'hFE208EE3};
    tbl[5] = '{7, 0, 0, 1, 0, 0, 32'h8,        1, 32'h008000EF};
    tbl[6] = '{4, 0, 0, 5, 0, 0, 32'h12345000, 1, 32'h123452B7};
    tbl[7] = '{0, 10, 0, 3, 1, 2, 32'h0,       0, 32'h0};
    tbl[8] = '{0, 0, 0, 3, 1, 2, 32'h0,        1, 32'h002081B3};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst we", 32'(bus.imem_we), 32'd0);
    chk("rst addr", bus.imem_addr, 32'd0);
    chk("rst wdata", bus.imem_wdata, 32'd0);
    chk("rst count", 32'(bus.count), 32'd0);
    chk("rst full", 32'(bus.full), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);

    for (int i = 0; i < 9; i++) do_req(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      v.fmt = 4'($urandom_range(0, 10));
      v.aop = 5'($urandom_range(0, 12));
      v.f3  = 3'($urandom);
      v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
      v.imm = $urandom;
      ref_enc(v, lg, w);
      v.legal = lg; v.word = w;
      do_req(v, $sformatf("rnd%0d", i));
    end

    // Capacity: small instance fed back-to-back until full
    @(negedge clk);
    sb.fmt = 0; sb.alu_op = 0; sb.rd = 3; sb.rs1 = 1; sb.rs2 = 2; sb.in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (sb.imem_we) waddrs.push_back(sb.imem_addr);
    end
    chk("cap writes", 32'(waddrs.size()), 32'd4);
    for (int i = 0; i < waddrs.size() && i < 4; i++)
      chk($sformatf("cap addr%0d", i), waddrs[i], 32'(i * 4));
    chk("cap full", 32'(sb.full), 32'd1);
    chk("cap ready", 32'(sb.in_ready), 32'd0);
    chk("cap count", 32'(sb.count), 32'd4);
    sb.done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("cap done_stall we", 32'(sb.imem_we), 32'd0);
    end
    chk("cap done_stall ready", 32'(sb.in_ready), 32'd0);
    sb.in_valid = 1'b0; sb.done = 1'b0;

    // Reset asserted during the write cycle
    @(negedge clk);
    drive(tbl[0], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_rst we_before", 32'(bus.imem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst we_async", 32'(bus.imem_we), 32'd0);
    chk("mid_rst count", 32'(bus.count), 32'd0);
    chk("mid_rst err", 32'(bus.err), 32'd0);
    chk("mid_rst ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0; exp_err = 1'b0;
    do_req(tbl[1], "post_rst");

    // End of program: no further writes once done is accepted
    @(negedge clk);
    drive(tbl[0], 1'b1);
    @(negedge clk);
    bus.done = 1'b0;
    chk("fin ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("fin we", 32'(bus.imem_we), 32'd0);
    end
    chk("fin count", 32'(bus.count), 32'(exp_count));
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
